// File: rtl/rf_pkg.sv
// Shared definitions for the register file with busy scoreboard:
// default geometry, a constant-foldable clog2 and a population count.
package rf_pkg;

  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_DEPTH      = 8;
  // Largest supported register count; popcount operates on this width.
  localparam int RF_MAX_DEPTH  = 64;

  // Smallest n with 2**n >= value; used for address and counter widths.
  function automatic int rf_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Number of set bits; callers zero-extend narrower vectors.
  function automatic int rf_popcount(input logic [RF_MAX_DEPTH-1:0] vec);
    int count;
    count = 0;
    for (int i = 0; i < RF_MAX_DEPTH; i++) begin
      count += int'(vec[i]);
    end
    return count;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking. A reserve marks a register pending, a write
// clears it; a same-address reserve wins. Exposes the next-state vector so
// the read ports and the busy counter see this cycle's updates.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH       = RF_DEPTH,
  parameter bit ZERO_REG    = 1'b1,
  localparam int ADDR_WIDTH  = rf_clog2(DEPTH),
  localparam int COUNT_WIDTH = rf_clog2(DEPTH + 1)
) (
  input  logic                   clock_reg,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic [ADDR_WIDTH-1:0]  write_address,
  input  logic                   reserve_enable,
  input  logic [ADDR_WIDTH-1:0]  reserve_address,
  output logic [DEPTH-1:0]       busy_next,
  output logic [COUNT_WIDTH-1:0] busy_count_next
);

  logic [DEPTH-1:0]        busy;
  logic [RF_MAX_DEPTH-1:0] busy_wide;

  // Next-state busy: clear on writeback, then set on reserve so reserve wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    busy_next = busy;
    if (write_enable)   busy_next[write_address]   = 1'b0;
    if (reserve_enable) busy_next[reserve_address] = 1'b1;
    if (ZERO_REG)       busy_next[0]               = 1'b0;
  end

  // Count pending registers in the next-state vector.
  always_comb begin
    busy_wide              = '0;
    busy_wide[DEPTH-1:0]   = busy_next;
    busy_count_next        = COUNT_WIDTH'(rf_popcount(busy_wide));
  end

  // Busy state register; reset drops every outstanding reservation.
  always_ff @(posedge clock_reg) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their inputs from before the edge, regardless of block order.
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file: one write port, two registered read ports with
// same-cycle write forwarding, optional hardwired zero register, and per-port
// busy flags plus a busy count from the reservation scoreboard.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int DEPTH       = RF_DEPTH,
  parameter bit ZERO_REG    = 1'b1,
  localparam int ADDR_WIDTH  = rf_clog2(DEPTH),
  localparam int COUNT_WIDTH = rf_clog2(DEPTH + 1)
) (
  input  logic                   clock_reg,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic [ADDR_WIDTH-1:0]  write_address,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic                   reserve_enable,
  input  logic [ADDR_WIDTH-1:0]  reserve_address,
  input  logic [ADDR_WIDTH-1:0]  register_address1,
  input  logic [ADDR_WIDTH-1:0]  register_address2,
  output logic [DATA_WIDTH-1:0]  register_data1,
  output logic [DATA_WIDTH-1:0]  register_data2,
  output logic                   register_busy1,
  output logic                   register_busy2,
  output logic [COUNT_WIDTH-1:0] busy_count
);

  logic [DATA_WIDTH-1:0]  registers [DEPTH];
  logic                   write_accept;
  logic [DATA_WIDTH-1:0]  read_data1_next;
  logic [DATA_WIDTH-1:0]  read_data2_next;
  logic [DEPTH-1:0]       busy_next;
  logic [COUNT_WIDTH-1:0] busy_count_next;

  // Writes to the hardwired zero register are dropped entirely.
  assign write_accept = write_enable && !(ZERO_REG && (write_address == '0));

  // Forwarding: an accepted write to the addressed register bypasses the array.
  assign read_data1_next = (ZERO_REG && (register_address1 == '0)) ? '0 :
                           (write_accept && (register_address1 == write_address)) ? write_data :
                           registers[register_address1];
  assign read_data2_next = (ZERO_REG && (register_address2 == '0)) ? '0 :
                           (write_accept && (register_address2 == write_address)) ? write_data :
                           registers[register_address2];

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clock_reg       (clock_reg),
    .reset           (reset),
    .write_enable    (write_enable),
    .write_address   (write_address),
    .reserve_enable  (reserve_enable),
    .reserve_address (reserve_address),
    .busy_next       (busy_next),
    .busy_count_next (busy_count_next)
  );

  // Register array: cleared by reset, written on accepted writeback.
  always_ff @(posedge clock_reg) begin
    // NOTE: the array is reset because the datapath relies on every register
    // reading zero after reset; it maps to flops, not a RAM macro.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) registers[i] <= '0;
    end else if (write_accept) begin
      registers[write_address] <= write_data;
    end
  end

  // Registered read outputs, busy flags and busy count (1-cycle latency).
  always_ff @(posedge clock_reg) begin
    if (reset) begin
      register_data1 <= '0;
      register_data2 <= '0;
      register_busy1 <= 1'b0;
      register_busy2 <= 1'b0;
      busy_count     <= '0;
    end else begin
      register_data1 <= read_data1_next;
      register_data2 <= read_data2_next;
      register_busy1 <= busy_next[register_address1];
      register_busy2 <= busy_next[register_address2];
      busy_count     <= busy_count_next;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a default 8x8 ZERO_REG=1 instance
// checked against a small reference model through an expectation queue, and a
// 16x32 ZERO_REG=0 instance checked against fixed values.
module tb_regfile_scoreboard;

  logic clock_reg = 1'b0;
  logic reset;
  always #5 clock_reg = ~clock_reg;

  // Default instance.
  logic       a_we, a_re;
  logic [2:0] a_wa, a_ra, a_a1, a_a2;
  logic [7:0] a_wd, a_d1, a_d2;
  logic       a_b1, a_b2;
  logic [3:0] a_cnt;

  // Wide instance.
  logic        b_we, b_re;
  logic [4:0]  b_wa, b_ra, b_a1, b_a2;
  logic [15:0] b_wd, b_d1, b_d2;
  logic        b_b1, b_b2;
  logic [5:0]  b_cnt;

  regfile_scoreboard dut_a (
    .clock_reg(clock_reg), .reset(reset),
    .write_enable(a_we), .write_address(a_wa), .write_data(a_wd),
    .reserve_enable(a_re), .reserve_address(a_ra),
    .register_address1(a_a1), .register_address2(a_a2),
    .register_data1(a_d1), .register_data2(a_d2),
    .register_busy1(a_b1), .register_busy2(a_b2), .busy_count(a_cnt)
  );

  regfile_scoreboard #(.DATA_WIDTH(16), .DEPTH(32), .ZERO_REG(1'b0)) dut_b (
    .clock_reg(clock_reg), .reset(reset),
    .write_enable(b_we), .write_address(b_wa), .write_data(b_wd),
    .reserve_enable(b_re), .reserve_address(b_ra),
    .register_address1(b_a1), .register_address2(b_a2),
    .register_data1(b_d1), .register_data2(b_d2),
    .register_busy1(b_b1), .register_busy2(b_b2), .busy_count(b_cnt)
  );

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic       b1;
    logic       b2;
    logic [3:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_mem [8] = '{default: 8'h00};
  logic [7:0] m_busy = 8'h00;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference read for the ZERO_REG=1 instance before this cycle's write lands.
  function automatic logic [7:0] model_read(input logic [2:0] addr, input logic we,
                                            input logic [2:0] wa, input logic [7:0] wd);
    if (addr == 3'd0) return 8'h00;
    if (we && addr == wa) return wd;
    return m_mem[addr];
  endfunction

  // One clock on the default instance: drive, predict, push, clock, pop, compare.
  task automatic step_a(input string tag, input logic rst, input logic we,
                        input logic [2:0] wa, input logic [7:0] wd,
                        input logic re, input logic [2:0] ra,
                        input logic [2:0] a1, input logic [2:0] a2);
    exp_t       e;
    logic [7:0] nb;
    int         cnt;
    reset = rst;
    a_we = we; a_wa = wa; a_wd = wd; a_re = re; a_ra = ra; a_a1 = a1; a_a2 = a2;
    b_we = 1'b0; b_re = 1'b0;
    if (rst) begin
      e = '0;
      for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
      m_busy = 8'h00;
    end else begin
      nb = m_busy;
      if (we && wa != 3'd0) nb[wa] = 1'b0;
      if (re && ra != 3'd0) nb[ra] = 1'b1;
      e.d1 = model_read(a1, we, wa, wd);
      e.d2 = model_read(a2, we, wa, wd);
      e.b1 = nb[a1];
      e.b2 = nb[a2];
      cnt = 0;
      for (int i = 0; i < 8; i++) cnt += int'(nb[i]);
      e.cnt = 4'(cnt);
      if (we && wa != 3'd0) m_mem[wa] = wd;
      m_busy = nb;
    end
    exp_q.push_back(e);
    @(posedge clock_reg);
    #1;
    e = exp_q.pop_front();
    check({tag, ".data1"}, 32'(a_d1), 32'(e.d1));
    check({tag, ".data2"}, 32'(a_d2), 32'(e.d2));
    check({tag, ".busy1"}, 32'(a_b1), 32'(e.b1));
    check({tag, ".busy2"}, 32'(a_b2), 32'(e.b2));
    check({tag, ".count"}, 32'(a_cnt), 32'(e.cnt));
  endtask

  // One clock on the wide instance; the default instance idles.
  task automatic step_b(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                        input logic re, input logic [4:0] ra,
                        input logic [4:0] a1, input logic [4:0] a2);
    reset = 1'b0;
    a_we = 1'b0; a_re = 1'b0;
    b_we = we; b_wa = wa; b_wd = wd; b_re = re; b_ra = ra; b_a1 = a1; b_a2 = a2;
    @(posedge clock_reg);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_we = 1'b0; a_wa = '0; a_wd = '0; a_re = 1'b0; a_ra = '0; a_a1 = '0; a_a2 = '0;
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_re = 1'b0; b_ra = '0; b_a1 = '0; b_a2 = '0;

    // Reset from power-up, preload every register with 0xFF, then reset again.
    step_a("init_reset", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++)
      step_a("preload", 1'b0, 1'b1, 3'(i), 8'hFF, 1'b0, 3'd0, 3'(i), 3'd0);
    step_a("preload_rd", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd7);
    check("preload_r3", 32'(a_d1), 32'h0000_00FF);
    step_a("reset_ff", 1'b1, 1'b1, 3'd3, 8'hAA, 1'b1, 3'd3, 3'd3, 3'd7);
    step_a("post_reset", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd7);
    check("post_reset_r3", 32'(a_d1), 32'h0000_0000);
    check("post_reset_r7", 32'(a_d2), 32'h0000_0000);
    check("post_reset_cnt", 32'(a_cnt), 32'h0000_0000);

    // Write then read, and same-cycle forwarding.
    step_a("wr_r3", 1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 3'd5, 3'd0);
    step_a("rd_r3", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd0);
    check("rd_r3_5a", 32'(a_d1), 32'h0000_005A);
    step_a("fwd_r3", 1'b0, 1'b1, 3'd3, 8'hC3, 1'b0, 3'd0, 3'd3, 3'd0);
    check("fwd_r3_c3", 32'(a_d1), 32'h0000_00C3);
    step_a("hold_r3", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd3);

    // Hardwired zero register ignores write and reserve.
    step_a("zero_reg", 1'b0, 1'b1, 3'd0, 8'h77, 1'b1, 3'd0, 3'd0, 3'd0);
    check("zero_reg_d1", 32'(a_d1), 32'h0000_0000);
    check("zero_reg_busy", 32'(a_b2), 32'h0000_0000);
    check("zero_reg_cnt", 32'(a_cnt), 32'h0000_0000);

    // Reserve two registers, then release one by writeback.
    step_a("res_r2", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd5);
    step_a("res_r5", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd2, 3'd5);
    check("res_cnt2", 32'(a_cnt), 32'h0000_0002);
    check("res_busy1", 32'(a_b1), 32'h0000_0001);
    step_a("same_port", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd5);
    step_a("rel_r2", 1'b0, 1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd2, 3'd5);
    check("rel_busy1", 32'(a_b1), 32'h0000_0000);
    check("rel_d1", 32'(a_d1), 32'h0000_0011);
    check("rel_cnt1", 32'(a_cnt), 32'h0000_0001);

    // Same-cycle reserve and write: data lands, reserve wins.
    step_a("res_wr_r4", 1'b0, 1'b1, 3'd4, 8'h99, 1'b1, 3'd4, 3'd4, 3'd0);
    check("res_wr_d1", 32'(a_d1), 32'h0000_0099);
    check("res_wr_busy", 32'(a_b1), 32'h0000_0001);
    check("res_wr_cnt", 32'(a_cnt), 32'h0000_0002);
    step_a("rd_r4", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4);
    step_a("wr_idle_r6", 1'b0, 1'b1, 3'd6, 8'h3C, 1'b0, 3'd0, 3'd4, 3'd6);

    // Reset mid-operation discards a reservation and a concurrent write.
    step_a("res_r1", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1, 3'd4);
    step_a("reset_mid", 1'b1, 1'b1, 3'd1, 8'h22, 1'b0, 3'd0, 3'd1, 3'd4);
    step_a("after_reset", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd1, 3'd4);
    check("after_reset_r1", 32'(a_d1), 32'h0000_0000);
    check("after_reset_busy", 32'(a_b1), 32'h0000_0000);
    check("after_reset_cnt", 32'(a_cnt), 32'h0000_0000);

    // Wide instance: register 0 is ordinary, top register reachable.
    step_b(1'b1, 5'd0, 16'hBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    check("w_fwd_r0", 32'(b_d1), 32'h0000_BEEF);
    step_b(1'b1, 5'd31, 16'hBEEF, 1'b0, 5'd0, 5'd0, 5'd31);
    check("w_rd_r0", 32'(b_d1), 32'h0000_BEEF);
    check("w_fwd_r31", 32'(b_d2), 32'h0000_BEEF);
    step_b(1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd31, 5'd0);
    check("w_rd_r31", 32'(b_d1), 32'h0000_BEEF);
    check("w_rd_r0_p2", 32'(b_d2), 32'h0000_BEEF);
    step_b(1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 5'd0, 5'd31);
    check("w_res_r0_busy", 32'(b_b1), 32'h0000_0001);
    check("w_res_r0_cnt", 32'(b_cnt), 32'h0000_0001);
    step_b(1'b1, 5'd31, 16'h1234, 1'b1, 5'd31, 5'd31, 5'd0);
    check("w_res_wr_d1", 32'(b_d1), 32'h0000_1234);
    check("w_res_wr_busy", 32'(b_b1), 32'h0000_0001);
    check("w_res_wr_cnt", 32'(b_cnt), 32'h0000_0002);
    step_b(1'b1, 5'd0, 16'h0000, 1'b0, 5'd0, 5'd0, 5'd31);
    check("w_rel_r0_busy", 32'(b_b1), 32'h0000_0000);
    check("w_rel_r0_data", 32'(b_d1), 32'h0000_0000);
    check("w_rel_cnt", 32'(b_cnt), 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised multi-register file with one write port, two read ports and a per-register busy scoreboard. It replaces the fixed 8x8 register file used by the datapath. Added capabilities: configurable width and depth, an optional hardwired zero register, same-cycle write-to-read forwarding, and reserve/release tracking so the control FSM can detect read-after-write hazards. It sits between the decode/control unit (reserve, read) and the ALU/memory writeback (write).

Parameters:
DATA_WIDTH, 8, bits per register
DEPTH, 8, number of registers; power of two, 2..64
ADDR_WIDTH, clog2(DEPTH), address width; derived, not overridden
ZERO_REG, 1, when 1 register 0 always reads 0 and is never busy

Ports:
clock_reg  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
write_enable  in  1  writeback strobe
write_address  in  ADDR_WIDTH  destination register
write_data  in  DATA_WIDTH  writeback data
reserve_enable  in  1  mark a register as pending (issue of a producer)
reserve_address  in  ADDR_WIDTH  register to reserve
register_address1  in  ADDR_WIDTH  read port 1 address
register_address2  in  ADDR_WIDTH  read port 2 address
register_data1  out  DATA_WIDTH  read port 1 data, registered
register_data2  out  DATA_WIDTH  read port 2 data, registered
register_busy1  out  1  port 1 register pending, registered
register_busy2  out  1  port 2 register pending, registered
busy_count  out  clog2(DEPTH+1)  number of busy registers, registered

Behaviour:
- Reset, sampled at the clock edge while reset=1:
  - all registers, busy bits, register_data1/2, register_busy1/2 and busy_count go to 0;
  - write_enable and reserve_enable are ignored that cycle.
- Write: write_enable=1 at an edge stores write_data into register[write_address] and clears its busy bit.
- Reserve: reserve_enable=1 sets busy[reserve_address].
- Same-address write and reserve in one cycle: the reserve wins. The data is written and busy stays 1, because a new producer is issued.
- Write to a non-busy register is legal. Data is updated and busy stays 0.
- Reads: 1-cycle latency. Address presented in cycle N; data and busy appear on the outputs after edge N+1 and hold until the next edge.
- Forwarding: if write_enable=1 and write_address equals a read address in the same cycle, that port's data output takes write_data, not the old contents.
- Busy output for each read port is the next-state busy bit, so same-cycle write, reserve and forwarding are all reflected.
- ZERO_REG=1:
  - writes to address 0 are discarded and are not forwarded (reading 0 always returns 0);
  - reserves to address 0 are ignored, so busy[0] is always 0.
- ZERO_REG=0: register 0 is an ordinary register.
- busy_count is the population count of the next-state busy vector, registered. It updates together with the read outputs and stays in range 0..DEPTH (0..DEPTH-1 when ZERO_REG=1).
- Both read ports may address the same register; each behaves independently and identically.
- Reset asserted mid-operation discards all pending reservations and data that cycle. The first legal access is the cycle after reset deasserts.
- Addresses are always in range because DEPTH is a power of two; there is no out-of-range handling.

Decomposition:
- Shared package rf_pkg holds:
  - default constants RF_DATA_WIDTH=8 and RF_DEPTH=8;
  - a clog2 function for ADDR_WIDTH and the busy_count width;
  - the popcount function.
- One sub-module, rf_scoreboard (parameters DEPTH and ZERO_REG). It holds the busy vector with reserve/clear priority and produces next-state busy plus busy_count.
- The data array, forwarding mux and output registers stay in regfile_scoreboard.

Test Plan:
1. Reset with all registers preloaded to 0xFF -> next cycle register_data1/2 = 0x00, busy1/2 = 0, busy_count = 0.
2. Write 0x5A to r3, read r3 on port 1 one cycle later -> register_data1 = 0x5A; same-cycle read of r3 during a write of 0xC3 -> register_data1 = 0xC3 (forwarding).
3. ZERO_REG=1: write 0x77 to r0 and reserve r0, read r0 on both ports -> data = 0x00, busy = 0, busy_count unchanged.
4. Reserve r2 and r5 -> busy_count = 2 and register_busy1 (addr 2) = 1. Then write r2 = 0x11 -> busy1 = 0, data1 = 0x11, busy_count = 1.
5. Reserve and write r4 in the same cycle with data 0x99 -> r4 reads 0x99, busy = 1, busy_count increments by 1.
6. Reserve r1, then assert reset while writing r1 = 0x22 -> after reset r1 reads 0x00, busy = 0, busy_count = 0. Repeat with DATA_WIDTH=16, DEPTH=32, ZERO_REG=0, writing 0xBEEF to r0 and r31 -> both read 0xBEEF.
